i2s_tx_master: RTL and testbench
================================

Name: i2s_tx_master

Overview:
I2S transmit master for the audio path; the playback counterpart of the I2S receive master. Generates SCK/WS, buffers right-aligned PCM words in an internal FIFO, and serialises them MSB-first onto SDO. Supports standard I2S (1-bit delay) and left-justified framing, with per-channel enable. Sits between the bus-interface FIFO write port and the external DAC/codec.

Parameters:
AW, 4, FIFO address width; depth = 2**AW words
DW, 32, FIFO data width; fixed at 32

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  transmitter enable
sck_prescaler  in  8  SCK half-period = sck_prescaler+1 clk cycles
sample_size  in  6  valid bits per sample, 1..32; 0 or >32 is treated as 32
left_justified  in  1  1: left-justified framing; 0: I2S framing
channels  in  2  [1] left enable, [0] right enable
fifo_wr  in  1  push fifo_wdata
fifo_wdata  in  32  sample, right-aligned in bits [sample_size-1:0]
fifo_flush  in  1  empty the FIFO
fifo_full  out  1  FIFO full
fifo_empty  out  1  FIFO empty
fifo_level  out  AW  FIFO occupancy
underrun  out  1  sticky; an enabled slot started with the FIFO empty
underrun_clr  in  1  clears underrun
sck  out  1  serial clock
ws  out  1  word select; 0 = left, 1 = right
sdo  out  1  serial data

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: sck=0, ws=1, sdo=0, underrun=0, prescaler=0, bit_ctr=0, shift register=0, FIFO empty (fifo_empty=1, fifo_full=0, fifo_level=0).
- Prescaler: 8-bit down-counter, advances only when en=1.
  - At 0: reloads sck_prescaler and sck toggles.
  - Otherwise: decrements.
- fall event: en=1, prescaler==0 and sck==1. All sdo, ws and bit_ctr updates occur only on fall events.
- bit_ctr: 5-bit, increments on every fall event and wraps 31->0.
- Slot boundary: a fall event with bit_ctr==0. On it, ws toggles. The first boundary after reset enters the left slot (ws 1->0). 32 SCK per slot, 64 per frame.
- Slot fetch, in the boundary cycle:
  - The new slot channel is ~ws_next = left when ws goes to 0.
  - Channel enabled and FIFO not empty: pop one word (first-word-fall-through read, same cycle) and load shift register with fifo_rdata << (32 - sample_size_eff). Bits below the sample are zero.
  - Channel enabled and FIFO empty: load zero and set underrun.
  - Channel disabled: load zero, no pop, no underrun.
  - Stereo (channels=11): left pops before right, so the FIFO holds L,R,L,R order.
- Left-justified framing: sdo = word bit 31 on the boundary fall event, then bits 30..0 on the following fall events.
- I2S framing: sdo lags by one SCK.
  - On the boundary fall, sdo = the last bit of the previous slot word.
  - Word bit 31 is driven on the next fall, and so on.
  - A 1-bit delay flop implements this.
- Timing guarantee: data changes only on SCK falling edges, so the receiver samples on rising edges.
- en=0: prescaler, sck, ws, bit_ctr, sdo and shift register hold their values; no pops. The FIFO still accepts writes. Re-asserting en resumes from the held state.
- FIFO corner cases:
  - fifo_wr when full is ignored.
  - fifo_wr and pop in the same cycle: both take effect and fifo_level is unchanged.
  - fifo_wr into an empty FIFO in the same cycle as a fetch: the fetch sees empty, so underrun is set and the write is kept.
  - fifo_flush takes priority over wr and pop in the same cycle.
- underrun: set has priority over underrun_clr in the same cycle.
- Mid-frame configuration changes to sample_size, left_justified or channels take effect at the next slot boundary. A sck_prescaler change takes effect at the next reload.

Decomposition:
- Shared package: SLOT_BITS=32, CH_LEFT=2'b10, CH_RIGHT=2'b01, CH_STEREO=2'b11, and an effective-sample-size function (0 or >32 -> 32).
- One sub-module: aucohl_fifo (DW=32, AW), the codebase's standard FIFO, used unchanged as the sample buffer.
- Serialiser, clock generator and underrun logic live in i2s_tx_master.

Test Plan:
- Reset, en=0 for 20 cycles -> sck=0, ws=1, sdo=0, fifo_empty=1, underrun=0 throughout.
- sck_prescaler=1, en=1 -> sck period 4 clk; ws toggles every 128 clk; first ws 1->0 on the first SCK falling edge.
- left_justified=1, sample_size=24, channels=11, push 0x00ABCDEF then 0x00123456:
  - left slot sdo = 1010_1011_1100_1101_1110_1111 then 8 zeros, MSB on the ws edge;
  - right slot carries 0x123456 the same way;
  - fifo_level 2->1->0.
- Same data with left_justified=0 -> identical bit streams delayed by exactly one SCK; first left bit = 0.
- channels=10, push 3 words -> only left slots pop; right slots sdo=0; level drops by 1 per frame; no underrun.
- channels=11, FIFO empty at a left boundary -> zero slot, underrun=1.
  - underrun_clr pulsed in the same cycle as the next empty fetch -> underrun stays 1.
  - A later clr with the FIFO non-empty -> underrun 0.
  - fifo_flush mid-frame -> level 0; the current slot finishes with its already-loaded word.

Source files
------------

// File: rtl/i2s_tx_master_pkg.sv
// Shared constants and helpers for the I2S transmit master.
package i2s_tx_master_pkg;

    localparam int unsigned SLOT_BITS = 32;

    localparam logic [1:0] CH_LEFT   = 2'b10;
    localparam logic [1:0] CH_RIGHT  = 2'b01;
    localparam logic [1:0] CH_STEREO = 2'b11;

    // Out-of-range sizes fall back to a full 32-bit slot.
    function automatic logic [5:0] eff_sample_size(input logic [5:0] size);
        return (size == 6'd0 || size > 6'd32) ? 6'd32 : size;
    endfunction

endpackage

// File: rtl/aucohl_fifo.sv
// Synchronous FIFO with first-word-fall-through read data and a synchronous flush.
module aucohl_fifo #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    input  logic          flush_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW-1:0] level_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_wr, do_rd;

    assign do_wr   = wr_i & ~full_o;
    assign do_rd   = rd_i & ~empty_o;
    assign full_o  = cnt_q[AW];
    assign empty_o = (cnt_q == '0);
    // Level wraps to zero when completely full; full_o disambiguates.
    assign level_o = cnt_q[AW-1:0];
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_wr && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            if (do_wr && !do_rd) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (do_rd && !do_wr) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_tx_master.sv
// I2S / left-justified transmit master: SCK/WS generation, sample FIFO and MSB-first serialiser.
module i2s_tx_master
    import i2s_tx_master_pkg::*;
#(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [7:0]    sck_prescaler,
    input  logic [5:0]    sample_size,
    input  logic          left_justified,
    input  logic [1:0]    channels,
    input  logic          fifo_wr,
    input  logic [DW-1:0] fifo_wdata,
    input  logic          fifo_flush,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW-1:0] fifo_level,
    output logic          underrun,
    input  logic          underrun_clr,
    output logic          sck,
    output logic          ws,
    output logic          sdo
);

    logic [7:0]           presc_q, presc_d;
    logic [4:0]           bit_ctr_q, bit_ctr_d;
    logic [SLOT_BITS-1:0] shift_q, shift_d;
    logic                 sck_q, sck_d;
    logic                 ws_q, ws_d;
    logic                 sdo_q, sdo_d;
    logic                 dly_q, dly_d;
    logic                 lj_q, lj_d;
    logic                 underrun_q, underrun_d;

    logic                 tick, fall, boundary, ch_en, pop, out_bit, lj_eff;
    logic [5:0]           ss_eff;
    logic [DW-1:0]        fifo_rdata;
    logic [SLOT_BITS-1:0] word;

    aucohl_fifo #(
        .DW (DW),
        .AW (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (fifo_wr),
        .wdata_i (fifo_wdata),
        .rd_i    (pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        tick     = en && (presc_q == 8'd0);
        fall     = tick && sck_q;
        boundary = fall && (bit_ctr_q == 5'd0);
        // ws_q still names the slot that is ending, so ws_q=1 means left is next.
        ch_en    = ws_q ? |(channels & CH_LEFT) : |(channels & CH_RIGHT);
        pop      = boundary && ch_en && !fifo_empty;
        ss_eff   = eff_sample_size(sample_size);
        word     = pop ? (fifo_rdata << (6'd32 - ss_eff)) : '0;
        lj_eff   = boundary ? left_justified : lj_q;
        out_bit  = boundary ? word[SLOT_BITS-1] : shift_q[SLOT_BITS-1];

        presc_d    = presc_q;
        sck_d      = sck_q;
        ws_d       = ws_q;
        bit_ctr_d  = bit_ctr_q;
        shift_d    = shift_q;
        sdo_d      = sdo_q;
        dly_d      = dly_q;
        lj_d       = lj_q;
        underrun_d = underrun_q;

        if (tick) begin
            presc_d = sck_prescaler;
            sck_d   = ~sck_q;
        end else if (en) begin
            presc_d = presc_q - 8'd1;
        end

        if (fall) begin
            bit_ctr_d = bit_ctr_q + 5'd1;
            shift_d   = boundary ? {word[SLOT_BITS-2:0], 1'b0}
                                 : {shift_q[SLOT_BITS-2:0], 1'b0};
            dly_d     = out_bit;
            // I2S framing replays the previous fall's bit for the one-SCK delay.
            sdo_d     = lj_eff ? out_bit : dly_q;
        end

        if (boundary) begin
            ws_d = ~ws_q;
            lj_d = left_justified;
        end

        if (boundary && ch_en && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b1;
            bit_ctr_q  <= '0;
            shift_q    <= '0;
            sdo_q      <= 1'b0;
            dly_q      <= 1'b0;
            lj_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            bit_ctr_q  <= bit_ctr_d;
            shift_q    <= shift_d;
            sdo_q      <= sdo_d;
            dly_q      <= dly_d;
            lj_q       <= lj_d;
            underrun_q <= underrun_d;
        end
    end

    assign sck      = sck_q;
    assign ws       = ws_q;
    assign sdo      = sdo_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Table-driven bench for i2s_tx_master: slot words are scoreboarded and rebuilt from sdo.
module tb_i2s_tx_master;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [7:0]    sck_prescaler;
    logic [5:0]    sample_size;
    logic          left_justified;
    logic [1:0]    channels;
    logic          fifo_wr;
    logic [31:0]   fifo_wdata;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW-1:0] fifo_level;
    logic          underrun;
    logic          underrun_clr;
    logic          sck;
    logic          ws;
    logic          sdo;

    always #5 clk = ~clk;

    i2s_tx_master #(
        .AW (AW),
        .DW (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .sck_prescaler  (sck_prescaler),
        .sample_size    (sample_size),
        .left_justified (left_justified),
        .channels       (channels),
        .fifo_wr        (fifo_wr),
        .fifo_wdata     (fifo_wdata),
        .fifo_flush     (fifo_flush),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_level     (fifo_level),
        .underrun       (underrun),
        .underrun_clr   (underrun_clr),
        .sck            (sck),
        .ws             (ws),
        .sdo            (sdo)
    );

    typedef struct {
        logic        lj;
        logic [5:0]  ss;
        logic [1:0]  ch;
        logic [31:0] wl;
        logic [31:0] wr;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] expq[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          fall_cnt = 0;
    int          cyc = 0;
    int          last_fall_cyc = 0;
    int          np;
    bit          period_armed = 1'b0;
    bit          cfg_lj = 1'b1;
    bit          cur_lj = 1'b1;
    logic [31:0] hist = '0;
    logic [31:0] last_exp = '0;
    logic        sck_prev = 1'b0;
    logic        sdo_prev = 1'b0;
    logic        ws_prev = 1'b1;
    logic        sck_hold;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic sb_pop(input logic [31:0] got, input bit skip_lsb);
        logic [31:0] want;
        logic [31:0] mask;
        if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL slot_word: got 0x%08h, want nothing (scoreboard empty)", got);
        end else begin
            want     = expq.pop_front();
            last_exp = want;
            mask     = skip_lsb ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
            check("slot_word", got & mask, want & mask);
        end
    endtask

    // One clk of progress; sdo is rebuilt into slot words on every SCK falling edge.
    task automatic tick();
        int idx;
        int slot;
        @(negedge clk);
        cyc++;
        if (sck_prev && !sck) begin
            idx  = fall_cnt % 32;
            slot = fall_cnt / 32;
            hist = {hist[30:0], sdo};
            check("ws_slot", ws, (slot % 2 == 0) ? 0 : 1);
            if (period_armed) check("sck_period", cyc - last_fall_cyc, 4);
            period_armed  = 1'b1;
            last_fall_cyc = cyc;
            if (idx == 0) begin
                // An I2S slot followed by a left-justified one loses its final bit.
                if (fall_cnt > 0 && !cur_lj) sb_pop(hist, cfg_lj);
                cur_lj = cfg_lj;
                if (!cur_lj) check("i2s_lead_bit", sdo, last_exp[0]);
            end
            if (idx == 31 && cur_lj) sb_pop(hist, 1'b0);
            fall_cnt++;
        end else begin
            check("sdo_stable", sdo, sdo_prev);
            check("ws_stable", ws, ws_prev);
        end
        sck_prev = sck;
        sdo_prev = sdo;
        ws_prev  = ws;
    endtask

    task automatic wait_target(input int target);
        int guard;
        guard = 0;
        while (fall_cnt < target && guard < 5000) begin
            tick();
            guard++;
        end
        if (fall_cnt < target) begin
            n_vec++;
            n_err++;
            $display("FAIL sck_timeout: got %0d falls, want %0d", fall_cnt, target);
        end
    endtask

    task automatic finish_slots(input int n);
        wait_target((fall_cnt / 32 + n) * 32);
    endtask

    task automatic push(input logic [31:0] w);
        fifo_wr    = 1'b1;
        fifo_wdata = w;
        tick();
        fifo_wr    = 1'b0;
    endtask

    // Called right after a slot's last fall: the write lands on the next boundary edge.
    task automatic push_at_boundary(input logic [31:0] w);
        tick();
        tick();
        tick();
        push(w);
    endtask

    task automatic set_cfg(input bit lj, input logic [5:0] ss, input logic [1:0] ch);
        left_justified = lj;
        cfg_lj         = lj;
        sample_size    = ss;
        channels       = ch;
    endtask

    initial begin
        //          lj    ss     ch     wl            wr            exp_l         exp_r
        vecs[0] = '{1'b1, 6'd24, 2'b11, 32'h00ABCDEF, 32'h00123456, 32'hABCDEF00, 32'h12345600};
        vecs[1] = '{1'b0, 6'd24, 2'b11, 32'h00ABCDEF, 32'h00123456, 32'hABCDEF00, 32'h12345600};
        vecs[2] = '{1'b1, 6'd16, 2'b11, 32'hFFFFBEEF, 32'h12348001, 32'hBEEF0000, 32'h80010000};
        vecs[3] = '{1'b1, 6'd0,  2'b11, 32'hDEADBEEF, 32'h01234567, 32'hDEADBEEF, 32'h01234567};
        vecs[4] = '{1'b0, 6'd40, 2'b11, 32'h80000001, 32'h7FFFFFFE, 32'h80000001, 32'h7FFFFFFE};
        vecs[5] = '{1'b1, 6'd1,  2'b11, 32'h00000001, 32'hFFFFFFFE, 32'h80000000, 32'h00000000};
        vecs[6] = '{1'b1, 6'd32, 2'b10, 32'hA5A5A5A5, 32'h11111111, 32'hA5A5A5A5, 32'h00000000};
        vecs[7] = '{1'b0, 6'd8,  2'b01, 32'h22222222, 32'h123456C3, 32'h00000000, 32'hC3000000};
        vecs[8] = '{1'b1, 6'd32, 2'b00, 32'h33333333, 32'h44444444, 32'h00000000, 32'h00000000};

        rst_n         = 1'b0;
        en            = 1'b0;
        sck_prescaler = 8'd1;
        set_cfg(1'b1, 6'd24, 2'b11);
        fifo_wr       = 1'b0;
        fifo_wdata    = '0;
        fifo_flush    = 1'b0;
        underrun_clr  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_state", {26'd0, sck, ws, sdo, fifo_empty, fifo_full, underrun, fifo_level},
                  {26'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        end

        for (int i = 0; i < 16; i++) begin
            push(32'h100 + i);
            if (i < 15) check("fill_level", fifo_level, i + 1);
        end
        check("full_flag", fifo_full, 1'b1);
        check("full_not_empty", fifo_empty, 1'b0);
        push(32'hDEAD_0000);
        check("full_hold", fifo_full, 1'b1);
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        check("flush_empty", {fifo_full, fifo_empty, fifo_level}, {1'b0, 1'b1, 4'd0});

        foreach (vecs[i]) begin
            np = 0;
            set_cfg(vecs[i].lj, vecs[i].ss, vecs[i].ch);
            if (vecs[i].ch[1]) begin push(vecs[i].wl); np++; end
            if (vecs[i].ch[0]) begin push(vecs[i].wr); np++; end
            expq.push_back(vecs[i].exp_l);
            expq.push_back(vecs[i].exp_r);
            check("lvl_pushed", fifo_level, np);
            en = 1'b1;
            finish_slots(1);
            check("lvl_after_left", fifo_level, vecs[i].ch[0]);
            finish_slots(1);
            check("lvl_after_frame", fifo_level, 0);
            check("no_underrun", underrun, 1'b0);
        end

        // Left channel only: one pop per frame, silent right slots.
        set_cfg(1'b1, 6'd32, 2'b10);
        push(32'hC0DE_0001);
        push(32'hC0DE_0002);
        push(32'hC0DE_0003);
        for (int k = 0; k < 3; k++) begin
            expq.push_back(32'hC0DE_0001 + k);
            expq.push_back(32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            finish_slots(2);
            check("lvl_left_only", fifo_level, 2 - k);
            check("left_only_no_underrun", underrun, 1'b0);
        end

        // Write into an empty FIFO on the fetch edge: fetch sees empty, write is kept.
        expq.push_back(32'h0);
        expq.push_back(32'h0);
        push_at_boundary(32'h1357_9BDF);
        check("underrun_wr_at_fetch", underrun, 1'b1);
        check("lvl_wr_at_fetch", fifo_level, 1);
        finish_slots(2);
        expq.push_back(32'h1357_9BDF);
        expq.push_back(32'h0);
        push_at_boundary(32'h2468_ACE0);
        check("lvl_wr_and_pop", fifo_level, 1);
        finish_slots(2);

        // Stereo with a starved right slot; clear collides with the set.
        set_cfg(1'b1, 6'd32, 2'b11);
        expq.push_back(32'h2468_ACE0);
        expq.push_back(32'h0);
        finish_slots(1);
        tick();
        tick();
        tick();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("set_beats_clr", underrun, 1'b1);
        finish_slots(1);
        expq.push_back(32'hF00D_0005);
        expq.push_back(32'hF00D_0006);
        push(32'hF00D_0005);
        underrun_clr = 1'b1;
        push(32'hF00D_0006);
        underrun_clr = 1'b0;
        check("clr_nonempty", underrun, 1'b0);
        check("lvl_two", fifo_level, 2);
        finish_slots(2);
        check("stereo_no_underrun", underrun, 1'b0);
        check("stereo_drained", fifo_level, 0);

        // Flush mid-slot: the loaded left word still goes out, right slot starves.
        expq.push_back(32'h7777_0007);
        expq.push_back(32'h0);
        push(32'h7777_0007);
        push(32'h8888_0008);
        wait_target(fall_cnt + 10);
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        check("flush_lvl", fifo_level, 0);
        check("flush_empty_mid", fifo_empty, 1'b1);
        finish_slots(2);
        check("flush_underrun", underrun, 1'b1);

        // en=0 mid-slot in I2S mode: everything holds, FIFO still takes writes.
        set_cfg(1'b0, 6'd32, 2'b11);
        expq.push_back(32'h8000_0003);
        expq.push_back(32'h5A5A_F00F);
        underrun_clr = 1'b1;
        push(32'h8000_0003);
        underrun_clr = 1'b0;
        push(32'h5A5A_F00F);
        check("clr_before_hold", underrun, 1'b0);
        wait_target(fall_cnt + 5);
        en           = 1'b0;
        period_armed = 1'b0;
        sck_hold     = sck;
        push(32'h9999_0011);
        check("lvl_write_while_off", fifo_level, 2);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("sck_hold", sck, sck_hold);
        end
        en = 1'b1;
        finish_slots(2);
        check("resume_no_underrun", underrun, 1'b0);
        set_cfg(1'b1, 6'd32, 2'b11);
        expq.push_back(32'h9999_0011);
        expq.push_back(32'h0);
        finish_slots(2);
        check("final_underrun", underrun, 1'b1);
        check("sb_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
